// File: rtl/icache_resp_pkg.sv
// icache_resp_pkg: shared constants, FSM state type and address-field widths for the instruction cache
package icache_resp_pkg;
  localparam logic [31:0] NOP_INST = 32'h00000033;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  function automatic int ow_f(input int words);
    return $clog2(words);
  endfunction
  function automatic int iw_f(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tw_f(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: flop-based valid/tag/data storage with combinational read, one write port and invalidate-all
module icache_array import icache_resp_pkg::*; #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [iw_f(LINES)-1:0]          rd_idx_i,
  input  logic [ow_f(WORDS)-1:0]          rd_word_i,
  output logic                            rd_valid_o,
  output logic [tw_f(LINES, WORDS)-1:0]   rd_tag_o,
  output logic [31:0]                     rd_data_o,
  input  logic                            we_i,
  input  logic [iw_f(LINES)-1:0]          wr_idx_i,
  input  logic [ow_f(WORDS)-1:0]          wr_word_i,
  input  logic [tw_f(LINES, WORDS)-1:0]   wr_tag_i,
  input  logic [31:0]                     wr_data_i,
  input  logic                            set_valid_i,
  input  logic                            inv_i
);
  localparam int TW = tw_f(LINES, WORDS);
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];
  // invalidate takes priority so a fence.i racing a final refill word leaves the line invalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else if (inv_i) valid_q <= '0;
    else if (set_valid_i) valid_q[wr_idx_i] <= 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      data_q[wr_idx_i][wr_word_i] <= wr_data_i;
    end
  end
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];
endmodule

// File: rtl/icache_resp.sv
// icache_resp: direct-mapped read-only instruction cache with zero-latency hits and sequential line refill
module icache_resp import icache_resp_pkg::*; #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  input  logic        i_inv,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);
  localparam int OW = ow_f(WORDS);
  localparam int IW = iw_f(LINES);
  localparam int TW = tw_f(LINES, WORDS);
  state_e          state_q, state_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [OW-1:0]   k_q, k_d;
  logic            blk_q, blk_d;
  logic [OW-1:0]   a_word;
  logic [IW-1:0]   a_idx;
  logic [TW-1:0]   a_tag;
  logic            rd_valid, hit, miss, we, set_v, unused_addr;
  logic [TW-1:0]   rd_tag;
  logic [31:0]     rd_data;
  assign a_word      = i_addr[2 +: OW];
  assign a_idx       = i_addr[2+OW +: IW];
  assign a_tag       = i_addr[31 -: TW];
  assign unused_addr = ^i_addr[1:0];
  assign hit         = i_req & rd_valid & (rd_tag == a_tag);
  // gating with reset keeps o_busy low while reset is held even if fetch keeps requesting
  assign miss        = i_req & ~hit & i_rst_n;
  assign o_busy      = (state_q != IDLE) | miss;
  assign o_rdata     = (state_q == IDLE && hit) ? rd_data : NOP_INST;
  assign o_mem_addr  = o_mem_ren ? {tag_q, idx_q, k_q, 2'b00} : '0;
  icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .rd_idx_i    (a_idx),
    .rd_word_i   (a_word),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .we_i        (we),
    .wr_idx_i    (idx_q),
    .wr_word_i   (k_q),
    .wr_tag_i    (tag_q),
    .wr_data_i   (i_mem_rdata),
    .set_valid_i (set_v),
    .inv_i       (i_inv)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      blk_q   <= blk_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    k_d       = k_q;
    we        = 1'b0;
    set_v     = 1'b0;
    o_mem_ren = 1'b0;
    case (state_q)
      IDLE: if (miss) begin
        state_d = REQ;
        tag_d   = a_tag;
        idx_d   = a_idx;
        k_d     = '0;
      end
      REQ: begin
        o_mem_ren = 1'b1;
        state_d   = i_mem_ready ? WAIT : REQ;
      end
      WAIT: if (i_mem_valid) begin
        we = 1'b1;
        if (k_q == OW'(WORDS - 1)) begin
          set_v   = ~blk_q;
          state_d = IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // a fence.i seen mid-refill must keep the refilled line from becoming valid
    blk_d = (state_d != IDLE) & (blk_q | (i_inv & (state_q != IDLE)));
  end
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed table and sequence checks of icache_resp against a behavioural backing memory
module tb_icache_resp;
  localparam logic [31:0] NOP = 32'h00000033;
  logic        clk = 1'b0;
  logic        rst_n, req, inv_main, inv_resp;
  logic [31:0] addr;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_rdata;
  wire         inv = inv_main | inv_resp;
  wire  [31:0] o_rdata, o_mem_addr;
  wire         o_busy, o_mem_ren;
  int checks = 0, fails = 0;
  int rdy_dly = 0, gap_max = 0, gap_fix = 0;
  bit inv_arm = 0;
  logic [31:0] inv_addr = '0;
  int inv_fired = 0, hold_bad = 0, hold_samples = 0;
  logic [31:0] log_q[$];

  icache_resp #(.LINES(16), .WORDS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_addr      (addr),
    .o_rdata     (o_rdata),
    .o_busy      (o_busy),
    .i_inv       (inv),
    .o_mem_ren   (o_mem_ren),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ready (mem_ready),
    .i_mem_valid (mem_valid),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // backing memory: one request at a time, programmable ready delay and data gaps
  initial begin
    bit pend = 0, have = 0;
    int rcnt = 0, vcnt = 0;
    logic [31:0] pa = '0, held = '0;
    mem_ready = 0; mem_valid = 0; mem_rdata = '0; inv_resp = 0;
    forever begin
      @(negedge clk);
      mem_ready = 0; mem_valid = 0; inv_resp = 0;
      if (!rst_n) begin
        pend = 0; have = 0;
      end else if (pend) begin
        if (vcnt == 0) begin
          mem_valid = 1;
          mem_rdata = mem_f(pa);
          if (inv_arm && inv_fired == 0 && pa == inv_addr) begin
            inv_resp = 1;
            inv_fired++;
          end
          pend = 0;
        end else vcnt--;
      end else if (o_mem_ren) begin
        if (!have) begin
          have = 1; held = o_mem_addr; rcnt = rdy_dly;
        end else begin
          hold_samples++;
          if (o_mem_addr !== held) hold_bad++;
        end
        if (rcnt == 0) begin
          mem_ready = 1; pend = 1; have = 0; pa = o_mem_addr;
          log_q.push_back(pa);
          vcnt = gap_fix + (gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
        end else rcnt--;
      end
    end
  end

  task automatic wait_idle(output int cnt);
    cnt = 1;
    while (o_busy && cnt < 3000) begin
      @(negedge clk); #1;
      if (o_busy) cnt++;
    end
    chk("busy_timeout", o_busy, 1'b0);
  endtask

  task automatic miss_seq(input logic [31:0] a, input int exp_cyc, input int reps);
    int base, cnt;
    logic [31:0] line;
    base = log_q.size();
    line = {a[31:4], 4'h0};
    @(negedge clk); req = 1; addr = a; #1;
    chk("miss_busy_same_cycle", o_busy, 1'b1);
    wait_idle(cnt);
    if (exp_cyc > 0) chk("miss_latency", cnt, exp_cyc);
    chk("miss_rdata", o_rdata, mem_f({a[31:2], 2'b00}));
    chk("refill_req_count", log_q.size() - base, 4 * reps);
    for (int r = 0; r < reps; r++)
      for (int w = 0; w < 4; w++)
        if (base + r * 4 + w < log_q.size())
          chk("refill_addr_order", log_q[base + r * 4 + w], line + 32'(w * 4));
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          busy;
    logic [31:0] rdata;
  } vec_t;

  initial begin
    vec_t vt[9];
    int cnt;
    vt[0] = '{1, 32'h140, 0, mem_f(32'h140)};
    vt[1] = '{1, 32'h144, 0, mem_f(32'h144)};
    vt[2] = '{1, 32'h148, 0, mem_f(32'h148)};
    vt[3] = '{1, 32'h14B, 0, mem_f(32'h148)};
    vt[4] = '{1, 32'h14C, 0, mem_f(32'h14C)};
    vt[5] = '{1, 32'h180, 0, mem_f(32'h180)};
    vt[6] = '{1, 32'h184, 0, mem_f(32'h184)};
    vt[7] = '{1, 32'h18E, 0, mem_f(32'h18C)};
    vt[8] = '{0, 32'h140, 0, NOP};
    rst_n = 0; req = 0; addr = '0; inv_main = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ren", o_mem_ren, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_rdata", o_rdata, NOP);
    #1 rst_n = 1;
    miss_seq(32'h100, 9, 1);
    @(negedge clk); addr = 32'h108; #1;
    chk("hit_108_busy", o_busy, 1'b0);
    chk("hit_108_rdata", o_rdata, mem_f(32'h108));
    @(negedge clk); addr = 32'h10B; #1;
    chk("hit_10B_rdata", o_rdata, mem_f(32'h108));
    miss_seq(32'h200, 9, 1);
    miss_seq(32'h100, 9, 1);
    inv_addr = 32'h188; inv_arm = 1;
    miss_seq(32'h180, 18, 2);
    inv_arm = 0;
    chk("inv_pulse_fired", inv_fired, 1);
    rdy_dly = 5; gap_max = 3;
    miss_seq(32'h140, 0, 1);
    rdy_dly = 0; gap_max = 0;
    chk("ren_hold_violations", hold_bad, 0);
    chk("ren_hold_samples", hold_samples, 20);
    foreach (vt[i]) begin
      @(negedge clk); req = vt[i].req; addr = vt[i].addr; #1;
      chk($sformatf("vec%0d_busy", i), o_busy, vt[i].busy);
      chk($sformatf("vec%0d_rdata", i), o_rdata, vt[i].rdata);
    end
    @(negedge clk); req = 1; addr = 32'h140; inv_main = 1; #1;
    chk("inv_idle_same_cycle_busy", o_busy, 1'b0);
    chk("inv_idle_same_cycle_rdata", o_rdata, mem_f(32'h140));
    @(negedge clk); inv_main = 0; #1;
    chk("inv_idle_next_miss", o_busy, 1'b1);
    wait_idle(cnt);
    chk("inv_idle_refill_rdata", o_rdata, mem_f(32'h140));
    rdy_dly = 3; gap_fix = 10;
    @(negedge clk); addr = 32'h100; #1;
    chk("rst_req_prep_busy", o_busy, 1'b1);
    @(negedge clk); #1;
    chk("rst_req_ren_before", o_mem_ren, 1'b1);
    rst_n = 0; rdy_dly = 0; #1;
    chk("rst_req_ren_async", o_mem_ren, 1'b0);
    chk("rst_req_busy_async", o_busy, 1'b0);
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_wait_busy_before", o_busy, 1'b1);
    chk("rst_wait_ren_before", o_mem_ren, 1'b0);
    rst_n = 0; #1;
    chk("rst_wait_busy_async", o_busy, 1'b0);
    chk("rst_wait_ren_async", o_mem_ren, 1'b0);
    chk("rst_wait_mem_addr", o_mem_addr, 32'h0);
    chk("rst_wait_rdata", o_rdata, NOP);
    req = 0; gap_fix = 0;
    @(negedge clk); #2 rst_n = 1;
    miss_seq(32'h100, 9, 1);
    miss_seq(32'h140, 9, 1);
    @(negedge clk); req = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
